mux_2x1_arbiter: RTL and testbench
==================================

MUX_2X1_ARBITER -- requirements
Module: mux_2x1_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each requester and of the output.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in0_valid, in1_valid  input  1 each  requester beat offered.
REQ-005 in0_data, in1_data  input  WIDTH each  requester payload.
REQ-006 in0_last, in1_last  input  1 each  final beat of requester packet.
REQ-007 in0_ready, in1_ready  output  1 each  requester beat accepted this cycle (combinational).
REQ-008 out_valid  output  1  registered output beat present.
REQ-009 out_data  output  WIDTH  registered payload of the winning requester.
REQ-010 out_last  output  1  registered copy of the winner's last flag.
REQ-011 out_src  output  1  index of the requester that supplied the current output beat.
REQ-012 out_ready  input  1  downstream accepts the output beat.

Function
REQ-013 The block SHALL share one registered output stage between two valid/ready requesters; a beat moves on in_valid&in_ready and out_valid&out_ready.
REQ-014 can_load = !out_valid | out_ready; in_ready of the granted requester SHALL equal can_load, and the other in_ready SHALL be 0.
REQ-015 Grant: in OWN0/OWN1 the owner; otherwise the only valid requester; if both are valid, the requester other than last_winner (round-robin).
REQ-016 On accept: out_data/out_last/out_src load the granted inputs, out_valid=1, last_winner=grant; latency input to output is exactly 1 cycle.
REQ-017 With no accept and out_ready=1, out_valid SHALL clear next cycle; with out_ready=0, all out_* SHALL hold stable.
REQ-018 Full throughput: back-to-back beats SHALL be accepted every cycle while out_ready=1.
REQ-019 State machine IDLE/OWN0/OWN1: IDLE->OWNg on an accepted beat from g with last=0; OWNg->IDLE on an accepted beat from g with last=1; otherwise hold.
REQ-020 In OWNg the other requester SHALL NOT be granted, even while ing_valid=0.
REQ-021 No valid requester: no grant, both in_ready=0, last_winner unchanged.

Reset
REQ-022 Under rst_n=0 at a clock edge: out_valid=0, out_data=0, out_last=0, out_src=0, state=IDLE, last_winner=1 (requester 0 wins the first tie).
REQ-023 Reset mid-packet or mid-stall SHALL discard the output beat and the lock; in_ready SHALL be 0 during the reset cycle.

Configuration
REQ-024 Macro ARB_PKT_LOCK_EN defined: packet locking per REQ-019/020.
REQ-025 ARB_PKT_LOCK_EN undefined: state is constantly IDLE, arbitration is per beat, in*_last pass through to out_last only; the port list is unchanged.

Structure
REQ-026 Package arb2_pkg SHALL hold the state enum (IDLE, OWN0, OWN1) and the source-index constants SRC0=0, SRC1=1.
REQ-027 The combinational round-robin pick SHALL be the sub-module rr_pick2 (inputs: two valids, last_winner, lock state; outputs: grant, grant_valid).

Verification
REQ-028 After reset, in0/in1 both valid, out_ready=1 -> grants alternate 0,1,0,1 on consecutive cycles; out_src follows one cycle later.
REQ-029 Only in1 valid with data 0xA5, last=1 -> in1_ready=1; next cycle out_valid=1, out_data=0xA5, out_src=1.
REQ-030 out_ready=0 with out_valid=1 -> both in_ready=0; out_data holds for 5 cycles; out_ready=1 -> beat drains and the next beat loads in the same cycle.
REQ-031 (ARB_PKT_LOCK_EN) in0 sends 3 beats, last on the 3rd, with a 2-cycle in0_valid gap while in1 is valid -> in1 is not granted until the cycle after in0's last beat is accepted.
REQ-032 rst_n=0 asserted during OWN1 with out_valid=1 -> next cycle out_valid=0, state IDLE; the first tie after reset is won by requester 0.

Source files
------------

// File: rtl/arb2_pkg.sv
// Shared types for the two-requester output arbiter: lock states and source indices.
// Lock states are only used when ARB_PKT_LOCK_EN is defined.
package arb2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/mux_2x1_arbiter_rr_pick2.sv
// Purpose: combinational round-robin pick between two requesters, honouring a packet lock.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller qualifies the grant with its own load enable.
module rr_pick2
    import arb2_pkg::*;
(
    input  logic       v0,
    input  logic       v1,
    input  logic       last_winner,
    input  arb_state_t state,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant       = SRC0;
        grant_valid = 1'b0;
        case (state)
            // A locked owner keeps the grant; the other side waits even if the owner idles.
            OWN0: begin
                grant       = SRC0;
                grant_valid = v0;
            end
            OWN1: begin
                grant       = SRC1;
                grant_valid = v1;
            end
            default: begin
                grant_valid = v0 | v1;
                if (v0 && v1) begin
                    grant = ~last_winner;
                end else if (v1) begin
                    grant = SRC1;
                end else begin
                    grant = SRC0;
                end
            end
        endcase
    end

endmodule

// File: rtl/mux_2x1_arbiter.sv
// Purpose: two valid/ready requesters share one registered output stage (round-robin).
// Latency: 1 cycle input to output; full throughput while out_ready=1.
// Backpressure: in*_ready = !out_valid | out_ready for the granted side only.
// Optional packet locking is enabled by defining ARB_PKT_LOCK_EN.
module mux_2x1_arbiter
    import arb2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready
);

    arb_state_t       state;
    logic             last_winner;
    logic             grant;
    logic             grant_valid;
    logic             can_load;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    rr_pick2 u_pick (
        .v0          (in0_valid),
        .v1          (in1_valid),
        .last_winner (last_winner),
        .state       (state),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Gating with rst_n keeps both requesters stalled during the reset cycle.
    assign can_load  = rst_n & (~out_valid | out_ready);
    assign accept    = grant_valid & can_load;
    assign in0_ready = accept & (grant == SRC0);
    assign in1_ready = accept & (grant == SRC1);
    assign sel_data  = (grant == SRC1) ? in1_data : in0_data;
    assign sel_last  = (grant == SRC1) ? in1_last : in0_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_src     <= SRC0;
            last_winner <= SRC1;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_data    <= sel_data;
            out_last    <= sel_last;
            out_src     <= grant;
            last_winner <= grant;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

`ifdef ARB_PKT_LOCK_EN
    arb_state_t state_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // While locked only the owner can be accepted, so sel_last is always the owner's flag.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!sel_last) begin
                        state_nxt = (grant == SRC1) ? OWN1 : OWN0;
                    end
                end
                OWN0, OWN1: begin
                    if (sel_last) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
`else
    assign state = IDLE;
`endif

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Directed bench for mux_2x1_arbiter: reset, round-robin, stall/drain, locking, reset mid-packet.
// Locking vectors are selected with ARB_PKT_LOCK_EN to match the DUT build.
module tb_mux_2x1_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in0_valid, in1_valid;
    logic [WIDTH-1:0] in0_data, in1_data;
    logic             in0_last, in1_last;
    logic             in0_ready, in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_src;
    logic             out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_2x1_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                         input logic v1, input logic [7:0] d1, input logic l1);
        in0_valid = v0; in0_data = d0; in0_last = l0;
        in1_valid = v1; in1_data = d1; in1_last = l1;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
        tick();
        tick();
        #1;
        check("rst_rdy0", in0_ready, 0);
        check("rst_rdy1", in1_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_src", out_src, 0);

        // Round-robin with both requesters valid: 0,1,0,1.
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b1, 1'b1, 8'(8'h20 + i), 1'b1);
            #1;
            check("rr_rdy0", in0_ready, (i % 2 == 0) ? 1 : 0);
            check("rr_rdy1", in1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            check("rr_valid", out_valid, 1);
            check("rr_src", out_src, i % 2);
            check("rr_data", out_data, (i % 2 == 0) ? 32'h10 + i : 32'h20 + i);
        end

        // No requester: nothing ready, output drains.
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("idle_rdy0", in0_ready, 0);
        check("idle_rdy1", in1_ready, 0);
        tick();
        check("idle_drain", out_valid, 0);

        // Single requester 1 with 0xA5.
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1);
        #1;
        check("solo_rdy1", in1_ready, 1);
        check("solo_rdy0", in0_ready, 0);
        tick();
        check("solo_valid", out_valid, 1);
        check("solo_data", out_data, 32'hA5);
        check("solo_src", out_src, 1);
        check("solo_last", out_last, 1);

        // Stall for 5 cycles, then drain and load in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0);
        #1;
        check("stall_rdy0", in0_ready, 0);
        check("stall_rdy1", in1_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, 32'hA5);
            check("stall_src", out_src, 1);
        end
        out_ready = 1'b1;
        #1;
        check("unstall_rdy0", in0_ready, 1);
        tick();
        check("unstall_data", out_data, 32'h33);
        check("unstall_src", out_src, 0);
        check("unstall_valid", out_valid, 1);

`ifdef ARB_PKT_LOCK_EN
        // in0 three-beat packet with a 2-cycle gap while in1 waits.
        drive(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("lk_b1_rdy0", in0_ready, 1);
        tick();
        check("lk_b1_data", out_data, 32'h41);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h51, 1'b1);
            #1;
            check("lk_gap_rdy1", in1_ready, 0);
            check("lk_gap_rdy0", in0_ready, 0);
            tick();
        end
        check("lk_gap_drain", out_valid, 0);
        drive(1'b1, 8'h42, 1'b0, 1'b1, 8'h51, 1'b1);
        #1;
        check("lk_b2_rdy0", in0_ready, 1);
        check("lk_b2_rdy1", in1_ready, 0);
        tick();
        check("lk_b2_data", out_data, 32'h42);
        drive(1'b1, 8'h43, 1'b1, 1'b1, 8'h51, 1'b1);
        #1;
        check("lk_b3_rdy0", in0_ready, 1);
        check("lk_b3_rdy1", in1_ready, 0);
        tick();
        check("lk_b3_data", out_data, 32'h43);
        check("lk_b3_last", out_last, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h51, 1'b1);
        #1;
        check("lk_rel_rdy1", in1_ready, 1);
        tick();
        check("lk_rel_src", out_src, 1);
        check("lk_rel_data", out_data, 32'h51);
`else
        // Per-beat arbitration: a non-last beat from in0 does not hold off in1.
        drive(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("pb_b1_rdy0", in0_ready, 1);
        tick();
        check("pb_b1_data", out_data, 32'h41);
        check("pb_b1_last", out_last, 0);
        drive(1'b1, 8'h42, 1'b0, 1'b1, 8'h51, 1'b1);
        #1;
        check("pb_b2_rdy1", in1_ready, 1);
        check("pb_b2_rdy0", in0_ready, 0);
        tick();
        check("pb_b2_src", out_src, 1);
        check("pb_b2_data", out_data, 32'h51);
        check("pb_b2_last", out_last, 1);
`endif

        // Start an in1 packet (locks in OWN1 when enabled), then reset with the beat stalled.
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h61, 1'b0);
        #1;
        check("pre_rst_rdy1", in1_ready, 1);
        tick();
        check("pre_rst_data", out_data, 32'h61);
        check("pre_rst_src", out_src, 1);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        drive(1'b1, 8'h71, 1'b1, 1'b1, 8'h72, 1'b1);
        #1;
        check("mid_rst_rdy0", in0_ready, 0);
        check("mid_rst_rdy1", in1_ready, 0);
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_rdy0", in0_ready, 1);
        check("post_rst_rdy1", in1_ready, 0);
        tick();
        check("post_rst_src", out_src, 0);
        check("post_rst_data", out_data, 32'h71);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
